// File: rtl/decode_stage.sv
// decode_stage: ID stage with 32x32 register file, ALUOp/imm/dest decode and a one-entry output register (optional DECODE_WB_BYPASS_EN)
module decode_stage #(
  parameter int          NUM_REGS = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] pc_in,
  input  logic [31:0] insn_in,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] pc_out,
  output logic [31:0] insn_out,
  output logic [31:0] rsData,
  output logic [31:0] rtData,
  output logic [31:0] imm,
  output logic [5:0]  ALUOp,
  output logic [4:0]  dest_reg,
  output logic        reg_write
);
  logic [31:0] regs [NUM_REGS];
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs_idx;
  logic [4:0]  rt_idx;
  logic [4:0]  rd_idx;
  logic [15:0] imm16;
  logic        wb_hit;
  logic        r_type;
  logic        i_write;
  logic        zext;
  logic        transfer;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] imm_d;
  logic [5:0]  alu_op_d;
  logic [4:0]  dest_d;
  logic        wr_d;
  assign opcode   = insn_in[31:26];
  assign funct    = insn_in[5:0];
  assign rs_idx   = insn_in[25:21];
  assign rt_idx   = insn_in[20:16];
  assign rd_idx   = insn_in[15:11];
  assign imm16    = insn_in[15:0];
  assign wb_hit   = wb_en && (wb_addr != 5'd0);
  assign in_ready = !out_valid || out_ready;
  assign transfer = in_valid && in_ready;
  // Register-file read ports; a same-cycle write is forwarded only in the bypass build
`ifdef DECODE_WB_BYPASS_EN
  always_comb begin
    rs_val = (rs_idx == 5'd0) ? 32'd0 : (wb_hit && wb_addr == rs_idx) ? wb_data : regs[rs_idx];
    rt_val = (rt_idx == 5'd0) ? 32'd0 : (wb_hit && wb_addr == rt_idx) ? wb_data : regs[rt_idx];
  end
`else
  always_comb begin
    rs_val = (rs_idx == 5'd0) ? 32'd0 : regs[rs_idx];
    rt_val = (rt_idx == 5'd0) ? 32'd0 : regs[rt_idx];
  end
`endif
  // Instruction decode: ALU operation, destination, write flag and immediate
  always_comb begin
    r_type   = (opcode == 6'h00);
    i_write  = (opcode == 6'h08) || (opcode == 6'h09) || (opcode == 6'h0C) || (opcode == 6'h0D) ||
               (opcode == 6'h0E) || (opcode == 6'h0F) || (opcode == 6'h23);
    zext     = (opcode == 6'h0C) || (opcode == 6'h0D) || (opcode == 6'h0E);
    alu_op_d = !r_type ? 6'b000000 : (funct == 6'h20) ? 6'b000001 : (funct == 6'h21) ? 6'b000010 : 6'b000000;
    dest_d   = r_type ? rd_idx : i_write ? rt_idx : 5'd0;
    wr_d     = (r_type ? (alu_op_d != 6'd0) : i_write) && (dest_d != 5'd0);
    imm_d    = (opcode == 6'h0F) ? {imm16, 16'h0000} : zext ? {16'h0000, imm16} : {{16{imm16[15]}}, imm16};
  end
  // Register file: write-back port, register 0 never written, cleared on reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_hit) begin
      regs[wb_addr] <= wb_data;
    end
  end
  // Output pipeline register: flush beats transfer, stall holds, drain clears valid
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      pc_out    <= RESET_PC;
      insn_out  <= '0;
      rsData    <= '0;
      rtData    <= '0;
      imm       <= '0;
      ALUOp     <= '0;
      dest_reg  <= '0;
      reg_write <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (transfer) begin
      out_valid <= 1'b1;
      pc_out    <= pc_in;
      insn_out  <= insn_in;
      rsData    <= rs_val;
      rtData    <= rt_val;
      imm       <= imm_d;
      ALUOp     <= alu_op_d;
      dest_reg  <= dest_d;
      reg_write <= wr_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed self-checking bench for decode_stage
module tb_decode_stage;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pc_in;
  logic [31:0] insn_in;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] pc_out;
  logic [31:0] insn_out;
  logic [31:0] rsData;
  logic [31:0] rtData;
  logic [31:0] imm;
  logic [5:0]  ALUOp;
  logic [4:0]  dest_reg;
  logic        reg_write;
  int total = 0;
  int bad = 0;

  decode_stage dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .insn_in(insn_in), .flush(flush), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
    .pc_out(pc_out), .insn_out(insn_out), .rsData(rsData), .rtData(rtData),
    .imm(imm), .ALUOp(ALUOp), .dest_reg(dest_reg), .reg_write(reg_write)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1;
    wb_addr = a;
    wb_data = d;
  endtask

  task automatic send(input logic [31:0] pc, input logic [31:0] insn);
    in_valid = 1'b1;
    pc_in = pc;
    insn_in = insn;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; pc_in = '0; insn_in = '0; flush = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
    #3;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_aluop", 32'(ALUOp), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_insn", insn_out, 32'd0);
    #9 reset_n = 1'b1;
    wb(5'd1, 32'd5);
    tick;
    wb(5'd2, 32'd7);
    tick;
    wb_en = 1'b0;
    chk("idle_valid", 32'(out_valid), 32'd0);
    send(32'h40, 32'h0022_1820);
    tick;
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_rs", rsData, 32'd5);
    chk("add_rt", rtData, 32'd7);
    chk("add_aluop", 32'(ALUOp), 32'd1);
    chk("add_dest", 32'(dest_reg), 32'd3);
    chk("add_wr", 32'(reg_write), 32'd1);
    chk("add_pc", pc_out, 32'h40);
    chk("add_insn", insn_out, 32'h0022_1820);
    send(32'h44, 32'h2021_FFFF);
    tick;
    chk("addi_imm", imm, 32'hFFFF_FFFF);
    chk("addi_aluop", 32'(ALUOp), 32'd0);
    chk("addi_dest", 32'(dest_reg), 32'd1);
    chk("addi_wr", 32'(reg_write), 32'd1);
    chk("addi_rs", rsData, 32'd5);
    send(32'h48, 32'h3421_FFFF);
    tick;
    chk("ori_imm", imm, 32'h0000_FFFF);
    send(32'h4C, 32'h3C01_1234);
    tick;
    chk("lui_imm", imm, 32'h1234_0000);
    send(32'h50, 32'h3021_8000);
    tick;
    chk("andi_imm", imm, 32'h0000_8000);
    send(32'h54, 32'h0022_1821);
    tick;
    chk("addu_aluop", 32'(ALUOp), 32'd2);
    chk("addu_wr", 32'(reg_write), 32'd1);
    send(32'h58, 32'h0022_1822);
    tick;
    chk("sub_aluop", 32'(ALUOp), 32'd0);
    chk("sub_wr", 32'(reg_write), 32'd0);
    send(32'h5C, 32'h0022_0020);
    tick;
    chk("rd0_aluop", 32'(ALUOp), 32'd1);
    chk("rd0_wr", 32'(reg_write), 32'd0);
    send(32'h60, 32'h1022_FFFF);
    tick;
    chk("beq_wr", 32'(reg_write), 32'd0);
    chk("beq_imm", imm, 32'hFFFF_FFFF);
    chk("beq_pc", pc_out, 32'h60);
    out_ready = 1'b0;
    send(32'h64, 32'h0022_1821);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("bp_ready", 32'(in_ready), 32'd0);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_pc", pc_out, 32'h60);
      chk("bp_insn", insn_out, 32'h1022_FFFF);
      chk("bp_imm", imm, 32'hFFFF_FFFF);
    end
    out_ready = 1'b1;
    #1 chk("bp_ready_up", 32'(in_ready), 32'd1);
    tick;
    chk("bp_load_pc", pc_out, 32'h64);
    chk("bp_load_aluop", 32'(ALUOp), 32'd2);
    in_valid = 1'b0;
    wb(5'd0, 32'd9);
    tick;
    wb_en = 1'b0;
    chk("drain_valid", 32'(out_valid), 32'd0);
    send(32'h68, 32'h0001_2820);
    tick;
    chk("r0_rs", rsData, 32'd0);
    chk("r0_rt", rtData, 32'd5);
    in_valid = 1'b0;
    wb(5'd4, 32'h1111);
    tick;
    wb(5'd4, 32'hDEAD);
    send(32'h6C, 32'h0080_3021);
    tick;
    wb_en = 1'b0;
`ifdef DECODE_WB_BYPASS_EN
    chk("byp_rs", rsData, 32'hDEAD);
`else
    chk("byp_rs", rsData, 32'h1111);
`endif
    send(32'h70, 32'h0080_3021);
    tick;
    chk("byp_next_rs", rsData, 32'hDEAD);
    flush = 1'b1;
    wb(5'd7, 32'h77);
    send(32'h80, 32'h0022_1820);
    tick;
    flush = 1'b0;
    wb_en = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 32'(out_valid), 32'd0);
    tick;
    chk("flush_drop", 32'(out_valid), 32'd0);
    send(32'h84, 32'h00E0_4020);
    tick;
    chk("flush_wb_rs", rsData, 32'h77);
    chk("flush_after_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b0;
    send(32'h88, 32'h0022_1820);
    tick;
    chk("stall_ready", 32'(in_ready), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_pc", pc_out, 32'h0);
    chk("mrst_rs", rsData, 32'd0);
    chk("mrst_ready", 32'(in_ready), 32'd1);
    #1 reset_n = 1'b1;
    out_ready = 1'b1;
    tick;
    chk("mrst_load_pc", pc_out, 32'h88);
    chk("mrst_rf_rs", rsData, 32'd0);
    chk("mrst_rf_rt", rtData, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
